aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10, number of AES rounds; only 10 (AES-128) is supported, and other values are a compile-time error.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  a block/key pair is offered.
REQ-005 SHALL have port in_ready  output  1  the controller accepts a pair this cycle.
REQ-006 SHALL have port datain  input  128  plaintext block, byte 0 in bits [127:120].
REQ-007 SHALL have port key  input  128  cipher key, same byte order.
REQ-008 SHALL have port out_valid  output  1  dataout holds a finished ciphertext.
REQ-009 SHALL have port out_ready  input  1  the consumer takes dataout.
REQ-010 SHALL have port dataout  output  128  ciphertext.
REQ-011 SHALL have port busy  output  1  high in ROUND and DONE.
REQ-012 SHALL have port round_idx  output  4  current round number (0..10), for debug.

Function
REQ-013 SHALL implement FSM states IDLE, ROUND and DONE, encoded in the shared package.
REQ-014 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE).
REQ-015 Accept edge: in IDLE with in_valid=1, the block SHALL load st<=datain^key, rk<=key, round_idx<=1, and go to ROUND.
REQ-016 ROUND edge: the block SHALL compute rk_n=key_step(rk, rcon[round_idx]), then load st<=round(st, rk_n, mix=(round_idx!=10)) and rk<=rk_n; it SHALL then increment round_idx.
REQ-017 rcon sequence SHALL be 01,02,04,08,10,20,40,80,1B,36, indexed by round_idx 1..10.
REQ-018 key_step SHALL be standard AES-128 expansion: w0'=w0^SubWord(RotWord(w3))^{rcon,00,00,00}, and each subsequent word w_i'=w_i^w_(i-1)'.
REQ-019 round() SHALL apply SubBytes, ShiftRows, MixColumns (skipped when mix=0), then AddRoundKey, in that order.
REQ-020 The ROUND edge with round_idx==10 SHALL transition to DONE and leave round_idx at 10.
REQ-021 Latency SHALL be exactly 10 clock edges: out_valid rises on the 10th edge after the accept edge.
REQ-022 dataout SHALL equal st while in DONE and SHALL hold stable until handshake; outside DONE its value is don't-care.
REQ-023 DONE with out_ready=1 SHALL return to IDLE, with round_idx<=0; DONE with out_ready=0 SHALL hold indefinitely (back-pressure).
REQ-024 in_valid SHALL be ignored in ROUND and DONE; datain and key SHALL be sampled only at the accept edge and may change afterwards.
REQ-025 No new pair SHALL be accepted in the same cycle as the DONE->IDLE handshake; the earliest next accept is the following edge.
REQ-026 The block SHALL have no combinational path from any input to in_ready or out_valid.

Reset
REQ-027 rst=1 at an edge SHALL force state=IDLE, round_idx=0, st=0 and rk=0, overriding any handshake in the same cycle.
REQ-028 Reset SHALL take effect from any state, including mid-ROUND; the in-flight block SHALL be discarded with no out_valid pulse.
REQ-029 After reset: in_ready=1, out_valid=0, busy=0, dataout=0.

Structure
REQ-030 Package aes_pkg SHALL hold the FSM state enum, the rcon table, the S-box function and the xtime/MixColumns helpers.
REQ-031 One combinational sub-module, aes_round_comb (inputs state, round key, mix; output next state), SHALL hold the round datapath; key_step and the FSM SHALL stay in aes_round_ctrl.

Verification
REQ-032 FIPS-197 App. B: datain 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> dataout 3925841d02dc09fbdc118597196a0b32, out_valid on the 10th edge after accept.
REQ-033 FIPS-197 App. C.1: datain 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> dataout 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-034 Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> dataout stable, in_ready=0 throughout; then out_ready=1 -> IDLE on the next edge.
REQ-035 Busy-ignore: pulse in_valid with other data at round_idx=4, and change datain/key mid-ROUND -> the App. B result is unchanged and no second accept occurs.
REQ-036 Reset mid-operation: assert rst at round_idx=6 -> the next cycle shows IDLE, round_idx=0, dataout=0, and out_valid never asserts; a following App. C.1 run is still correct.
REQ-037 Back-to-back: in_valid held high with out_ready=1 -> accepts are spaced 12 edges apart (accept, 10 rounds, handshake), and each result matches its vector.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: controller states, round constants, S-box and
// MixColumns helpers used by the round datapath and key expansion.
package aes_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Row-major S-box; entry 0 sits in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Top bit of entry b is 2047-8b, which is the 11-bit complement of 8b.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[~{b, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // 2a^3b^c^d written as 2(a^b)^b^c^d for each row.
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0 ^ a1) ^ a1 ^ a2 ^ a3,
            xtime(a1 ^ a2) ^ a2 ^ a3 ^ a0,
            xtime(a2 ^ a3) ^ a3 ^ a0 ^ a1,
            xtime(a3 ^ a0) ^ a0 ^ a1 ^ a2};
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One AES round as pure combinational logic: SubBytes, ShiftRows,
// optional MixColumns, AddRoundKey.
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic         mix,
  output logic [127:0] nxt
);
  logic [0:15][7:0] s_in;
  logic [0:15][7:0] sr;
  logic [0:3][31:0] mc;

  assign s_in = st;

  // Byte 4c+r is row r of column c; row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[4*c+r] = sbox(s_in[4*((c+r)%4)+r]);
    end
    assign mc[c] = mix ? mix_col({sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]})
                       : {sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]};
  end

  assign nxt = mc ^ rk;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, on-the-fly key expansion,
// valid/ready handshakes on both sides.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] datain,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dataout,
  output logic         busy,
  output logic [3:0]   round_idx
);
  if (NR != 10) begin : g_nr_check
    $error("aes_round_ctrl: only NR=10 (AES-128) is supported");
  end

  localparam logic [3:0] LAST = 4'(NR);

  state_t       state, state_n;
  logic [127:0] st, rk, rk_next, st_next;

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w0 = w0 ^ {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
            ^ {rc, 24'h000000};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign rk_next = key_step(rk, rcon(round_idx));

  aes_round_comb u_round (
    .st  (st),
    .rk  (rk_next),
    .mix (round_idx != LAST),
    .nxt (st_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      st        <= '0;
      rk        <= '0;
      round_idx <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: if (in_valid) begin
          st        <= datain ^ key;
          rk        <= key;
          round_idx <= 4'd1;
        end
        S_ROUND: begin
          st <= st_next;
          rk <= rk_next;
          if (round_idx != LAST) round_idx <= round_idx + 4'd1;
        end
        S_DONE: if (out_ready) round_idx <= '0;
        default: ;
      endcase
    end
  end

  // Handshake outputs decode the registered state only.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = S_ROUND;
      end
      S_ROUND: begin
        busy = 1'b1;
        if (round_idx == LAST) state_n = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign dataout = st;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: known-answer vectors plus handshake,
// back-pressure, busy-ignore and reset sequences.
module tb_aes_round_ctrl;
  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] datain, key, dataout;
  logic [3:0]   round_idx;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [127:0] pt;
    logic [127:0] k;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs[3];

  aes_round_ctrl #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .datain    (datain),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dataout   (dataout),
    .busy      (busy),
    .round_idx (round_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic scramble();
    datain = {$urandom, $urandom, $urandom, $urandom};
    key    = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic accept(input vec_t v);
    datain   = v.pt;
    key      = v.k;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    scramble();
    chk("accept_idx", round_idx, 4'd1);
    chk("accept_busy", busy, 1'b1);
    chk("accept_in_ready", in_ready, 1'b0);
  endtask

  // Runs edges 1..10 after accept; out_valid must stay low until edge 10.
  task automatic finish_rounds(input vec_t v, input string tag);
    logic early;
    early = 1'b0;
    for (int i = 1; i < 10; i++) begin
      tick();
      early |= out_valid;
    end
    chk({tag, "_early_valid"}, early, 1'b0);
    tick();
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_data"}, dataout, v.ct);
    chk({tag, "_idx"}, round_idx, 4'd10);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_hs_in_ready"}, in_ready, 1'b1);
    chk({tag, "_hs_out_valid"}, out_valid, 1'b0);
    chk({tag, "_hs_idx"}, round_idx, 4'd0);
  endtask

  initial begin
    logic [127:0] held;
    logic         bad;
    int           t_acc[3];

    vecs[0] = '{pt: 128'h3243f6a8885a308d313198a2e0370734,
                k:  128'h2b7e151628aed2a6abf7158809cf4f3c,
                ct: 128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{pt: 128'h00112233445566778899aabbccddeeff,
                k:  128'h000102030405060708090a0b0c0d0e0f,
                ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{pt: 128'h0,
                k:  128'h0,
                ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; datain = '0; key = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dataout", dataout, 128'h0);
    chk("rst_idx", round_idx, 4'd0);

    // Known-answer table
    for (int i = 0; i < 3; i++) begin
      accept(vecs[i]);
      finish_rounds(vecs[i], "kat");
      handshake("kat");
    end

    // Back-pressure with a competing offer during DONE
    accept(vecs[0]);
    finish_rounds(vecs[0], "bp");
    held = dataout;
    in_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      bad |= (dataout !== held) || (in_ready !== 1'b0) || (out_valid !== 1'b1);
    end
    chk("bp_hold_stable", bad, 1'b0);
    handshake("bp");
    in_valid = 1'b0;

    // Busy-ignore: offer other data at round 4, scramble inputs mid-round
    accept(vecs[0]);
    tick(); tick(); tick();
    chk("bi_idx4", round_idx, 4'd4);
    datain = vecs[1].pt; key = vecs[1].k; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    scramble();
    chk("bi_idx5", round_idx, 4'd5);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      bad |= out_valid;
    end
    chk("bi_early_valid", bad, 1'b0);
    tick();
    chk("bi_valid", out_valid, 1'b1);
    chk("bi_data", dataout, vecs[0].ct);
    handshake("bi");

    // Reset mid-ROUND discards the block
    accept(vecs[1]);
    for (int i = 0; i < 5; i++) tick();
    chk("rm_idx6", round_idx, 4'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_in_ready", in_ready, 1'b1);
    chk("rm_idx", round_idx, 4'd0);
    chk("rm_dataout", dataout, 128'h0);
    chk("rm_busy", busy, 1'b0);
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      bad |= out_valid;
    end
    chk("rm_no_valid", bad, 1'b0);
    accept(vecs[1]);
    finish_rounds(vecs[1], "rm_rerun");
    handshake("rm_rerun");

    // Reset overrides a handshake and an offer in DONE
    accept(vecs[2]);
    finish_rounds(vecs[2], "rd");
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    chk("rd_idx", round_idx, 4'd0);
    chk("rd_dataout", dataout, 128'h0);
    chk("rd_in_ready", in_ready, 1'b1);

    // Back-to-back: in_valid and out_ready held high
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      datain = vecs[k].pt; key = vecs[k].k;
      chk("b2b_in_ready", in_ready, 1'b1);
      tick();
      t_acc[k] = cyc;
      scramble();
      chk("b2b_accept_idx", round_idx, 4'd1);
      finish_rounds(vecs[k], "b2b");
      tick();
      chk("b2b_hs_in_ready", in_ready, 1'b1);
      chk("b2b_hs_idx", round_idx, 4'd0);
      if (k > 0) chk("b2b_spacing", t_acc[k] - t_acc[k-1], 12);
    end
    in_valid = 1'b0; out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
